// File: rtl/population_selector_if.sv
// population_selector_if: candidate stream in, published ranking out.
// The selector drives the ranking signals through the slave modport; the
// candidate source and ranking consumers use the master modport.
interface population_selector_if #(
   parameter int CHROM_W = 150,
   parameter int FIT_W   = 16,
   parameter int KEEP    = 10
) ();

   logic                    start;
   logic                    in_valid;
   logic [CHROM_W-1:0]      in_chrom;
   logic [FIT_W-1:0]        in_fitness;
   logic                    in_last;
   logic                    in_ready;
   logic [KEEP*CHROM_W-1:0] sel_population;
   logic [3:0]              sel_count;
   logic [FIT_W-1:0]        best_fitness;
   logic                    done;

   modport master (
      output start, in_valid, in_chrom, in_fitness, in_last,
      input  in_ready, sel_population, sel_count, best_fitness, done
   );

   modport slave (
      input  start, in_valid, in_chrom, in_fitness, in_last,
      output in_ready, sel_population, sel_count, best_fitness, done
   );

endinterface

// File: rtl/population_selector.sv
// population_selector: keeps the KEEP fittest chromosomes of a generation in
// descending-fitness order (stable on ties) and publishes them as one packed
// bus, best individual in the top slice, followed by a one-cycle done pulse.
// The published outputs stay frozen while the next generation is collected.
module population_selector #(
   parameter int CHROM_W = 150,
   parameter int FIT_W   = 16,
   parameter int KEEP    = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   population_selector_if.slave bus_if
);

   localparam int POP_W = KEEP * CHROM_W;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COLLECT = 2'd1;
   localparam logic [1:0] ST_PUBLISH = 2'd2;

   // Number of set bits in the working-slot valid vector.
   function automatic logic [3:0] count_valid(input logic [KEEP-1:0] vld);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int k = 0; k < KEEP; k++) begin
         if (vld[k]) begin
            cnt = cnt + 4'd1;
         end else begin
            cnt = cnt;
         end
      end
      return cnt;
   endfunction

   logic [1:0]         state_q, state_d;
   logic [KEEP-1:0]    slot_vld_q, slot_vld_d;
   logic [FIT_W-1:0]   slot_fit_q   [KEEP];
   logic [FIT_W-1:0]   slot_fit_d   [KEEP];
   logic [CHROM_W-1:0] slot_chrom_q [KEEP];
   logic [CHROM_W-1:0] slot_chrom_d [KEEP];

   logic               in_ready_q;
   logic               done_q;
   logic [POP_W-1:0]   sel_population_q;
   logic [3:0]         sel_count_q;
   logic [FIT_W-1:0]   best_fitness_q;

   logic               accept_s;
   logic               clear_s;
   logic [KEEP-1:0]    beats_s;
   logic [POP_W-1:0]   pub_pop_s;
   logic [FIT_W-1:0]   pub_best_s;

   assign accept_s = (state_q == ST_COLLECT) && bus_if.in_valid;
   assign clear_s  = (state_q == ST_IDLE) && bus_if.start;

   // Parallel compare: the candidate outranks a slot that is empty or strictly
   // weaker. Slots are kept sorted with valid entries first, so this vector is
   // monotonic and its first set bit is the insert position.
   always_comb begin
      for (int k = 0; k < KEEP; k++) begin
         beats_s[k] = !slot_vld_q[k] || (slot_fit_q[k] < bus_if.in_fitness);
      end
   end

   // Working-slot next state: clear on start, insert-and-shift on accept.
   always_comb begin
      slot_vld_d   = slot_vld_q;
      slot_fit_d   = slot_fit_q;
      slot_chrom_d = slot_chrom_q;
      if (clear_s) begin
         slot_vld_d = {KEEP{1'b0}};
         for (int k = 0; k < KEEP; k++) begin
            slot_fit_d[k]   = {FIT_W{1'b0}};
            slot_chrom_d[k] = {CHROM_W{1'b0}};
         end
      end else if (accept_s) begin
         if (beats_s[0]) begin
            slot_vld_d[0]   = 1'b1;
            slot_fit_d[0]   = bus_if.in_fitness;
            slot_chrom_d[0] = bus_if.in_chrom;
         end else begin
            slot_vld_d[0]   = slot_vld_q[0];
         end
         for (int k = 1; k < KEEP; k++) begin
            if (beats_s[k] && !beats_s[k-1]) begin
               slot_vld_d[k]   = 1'b1;
               slot_fit_d[k]   = bus_if.in_fitness;
               slot_chrom_d[k] = bus_if.in_chrom;
            end else if (beats_s[k]) begin
               slot_vld_d[k]   = slot_vld_q[k-1];
               slot_fit_d[k]   = slot_fit_q[k-1];
               slot_chrom_d[k] = slot_chrom_q[k-1];
            end else begin
               slot_vld_d[k]   = slot_vld_q[k];
            end
         end
      end else begin
         slot_vld_d = slot_vld_q;
      end
   end

   // Generation control: IDLE -> COLLECT on start, COLLECT -> PUBLISH on an
   // accepted last candidate, PUBLISH lasts exactly one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus_if.start) begin
               state_d = ST_COLLECT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (accept_s && bus_if.in_last) begin
               state_d = ST_PUBLISH;
            end else begin
               state_d = ST_COLLECT;
            end
         end
         ST_PUBLISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Publication image of the working slots; empty slots read as zero.
   always_comb begin
      pub_pop_s = {POP_W{1'b0}};
      for (int k = 0; k < KEEP; k++) begin
         if (slot_vld_q[k]) begin
            pub_pop_s[(KEEP-1-k)*CHROM_W +: CHROM_W] = slot_chrom_q[k];
         end else begin
            pub_pop_s[(KEEP-1-k)*CHROM_W +: CHROM_W] = {CHROM_W{1'b0}};
         end
      end
      if (slot_vld_q[0]) begin
         pub_best_s = slot_fit_q[0];
      end else begin
         pub_best_s = {FIT_W{1'b0}};
      end
   end

   // State, working slots and handshake flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         slot_vld_q <= {KEEP{1'b0}};
         for (int k = 0; k < KEEP; k++) begin
            slot_fit_q[k]   <= {FIT_W{1'b0}};
            slot_chrom_q[k] <= {CHROM_W{1'b0}};
         end
         in_ready_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         slot_vld_q   <= slot_vld_d;
         slot_fit_q   <= slot_fit_d;
         slot_chrom_q <= slot_chrom_d;
         in_ready_q   <= (state_d == ST_COLLECT);
         done_q       <= (state_q == ST_PUBLISH);
      end
   end

   // Published ranking registers: loaded only while in PUBLISH.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_population_q <= {POP_W{1'b0}};
         sel_count_q      <= 4'd0;
         best_fitness_q   <= {FIT_W{1'b0}};
      end else if (state_q == ST_PUBLISH) begin
         sel_population_q <= pub_pop_s;
         sel_count_q      <= count_valid(slot_vld_q);
         best_fitness_q   <= pub_best_s;
      end else begin
         sel_population_q <= sel_population_q;
         sel_count_q      <= sel_count_q;
         best_fitness_q   <= best_fitness_q;
      end
   end

   assign bus_if.in_ready       = in_ready_q;
   assign bus_if.done           = done_q;
   assign bus_if.sel_population = sel_population_q;
   assign bus_if.sel_count      = sel_count_q;
   assign bus_if.best_fitness   = best_fitness_q;

endmodule

// File: tb/tb_population_selector.sv
// Bench for population_selector: a reference ranking (stable descending sort
// of the whole generation) is queued when a generation's last candidate is
// driven and compared slot by slot when the DUT pulses done.
`timescale 1ns/1ps
module tb_population_selector;

   localparam int CHROM_W = 150;
   localparam int FIT_W   = 16;
   localparam int KEEP    = 10;
   localparam int POP_W   = KEEP * CHROM_W;

   typedef logic [159:0] val_t;
   typedef struct {
      logic [POP_W-1:0] pop;
      logic [3:0]       cnt;
      logic [FIT_W-1:0] best;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   population_selector_if #(.CHROM_W(CHROM_W), .FIT_W(FIT_W), .KEEP(KEEP)) bus_if ();

   population_selector #(.CHROM_W(CHROM_W), .FIT_W(FIT_W), .KEEP(KEEP)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus_if)
   );

   always #5 clk = ~clk;

   exp_t               exp_q[$];
   logic [POP_W-1:0]   pub_exp = '0;
   int                 n_checks = 0;
   int                 n_pass   = 0;
   int                 n_done   = 0;
   int                 n_pushed = 0;
   logic [FIT_W-1:0]   cand_fit   [32];
   logic [CHROM_W-1:0] cand_chrom [32];

   task automatic check_val(input string tag, input val_t obs, input val_t exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference ranking: stable descending insertion sort, keep the top KEEP.
   function automatic exp_t model(input int n);
      logic [FIT_W-1:0]   f [32];
      logic [CHROM_W-1:0] c [32];
      logic [FIT_W-1:0]   tf;
      logic [CHROM_W-1:0] tc;
      exp_t e;
      int j;
      for (int i = 0; i < n; i++) begin
         f[i] = cand_fit[i];
         c[i] = cand_chrom[i];
      end
      for (int i = 1; i < n; i++) begin
         j = i;
         while (j > 0 && f[j-1] < f[j]) begin
            tf = f[j-1]; f[j-1] = f[j]; f[j] = tf;
            tc = c[j-1]; c[j-1] = c[j]; c[j] = tc;
            j--;
         end
      end
      e.pop  = '0;
      e.cnt  = 4'((n < KEEP) ? n : KEEP);
      e.best = (n > 0) ? f[0] : '0;
      for (int k = 0; k < KEEP && k < n; k++) begin
         e.pop[(KEEP-1-k)*CHROM_W +: CHROM_W] = c[k];
      end
      return e;
   endfunction

   // Scoreboard consumer: every done pulse must match the oldest queued ranking.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst === 1'b1) begin
         pub_exp = '0;
      end else if (bus_if.done === 1'b1) begin
         n_done++;
         if (exp_q.size() == 0) begin
            check_val("unexpected_done", val_t'(1), val_t'(0));
         end else begin
            e = exp_q.pop_front();
            for (int k = 0; k < KEEP; k++) begin
               check_val($sformatf("slot%0d", k),
                         val_t'(bus_if.sel_population[(KEEP-1-k)*CHROM_W +: CHROM_W]),
                         val_t'(e.pop[(KEEP-1-k)*CHROM_W +: CHROM_W]));
            end
            check_val("sel_count", val_t'(bus_if.sel_count), val_t'(e.cnt));
            check_val("best_fitness", val_t'(bus_if.best_fitness), val_t'(e.best));
            pub_exp = e.pop;
         end
      end
   end

   task automatic check_zero(input string tag);
      check_val({tag, "_pop"}, val_t'(bus_if.sel_population == '0), val_t'(1));
      check_val({tag, "_cnt"}, val_t'(bus_if.sel_count), val_t'(0));
      check_val({tag, "_best"}, val_t'(bus_if.best_fitness), val_t'(0));
      check_val({tag, "_ready"}, val_t'(bus_if.in_ready), val_t'(0));
      check_val({tag, "_done"}, val_t'(bus_if.done), val_t'(0));
   endtask

   // Runs one generation of n candidates, starting in the current cycle.
   // restart_idx: candidate index that also carries a (to be ignored) start.
   // abort_pub: reset during the PUBLISH cycle instead of expecting done.
   task automatic run_gen(input int n, input int restart_idx, input bit abort_pub);
      bus_if.start = 1'b1;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      check_val("ready_after_start", val_t'(bus_if.in_ready), val_t'(1));
      for (int i = 0; i < n; i++) begin
         bus_if.in_valid   = 1'b1;
         bus_if.in_chrom   = cand_chrom[i];
         bus_if.in_fitness = cand_fit[i];
         bus_if.in_last    = (i == n - 1);
         bus_if.start      = (i == restart_idx);
         if (i == n - 1 && !abort_pub) begin
            exp_q.push_back(model(n));
            n_pushed++;
         end
         check_val("frozen", val_t'(bus_if.sel_population == pub_exp), val_t'(1));
         @(posedge clk); #1;
      end
      bus_if.in_valid = 1'b0;
      bus_if.in_last  = 1'b0;
      bus_if.start    = 1'b0;
      check_val("publish_ready", val_t'(bus_if.in_ready), val_t'(0));
      check_val("publish_no_done", val_t'(bus_if.done), val_t'(0));
      if (abort_pub) begin
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         check_zero("pub_rst");
         @(posedge clk); #1;
         check_val("no_done_after_rst", val_t'(bus_if.done), val_t'(0));
      end else begin
         @(posedge clk); #1;
         check_val("done_latency", val_t'(bus_if.done), val_t'(1));
         check_val("ready_in_done", val_t'(bus_if.in_ready), val_t'(0));
      end
   endtask

   function automatic logic [CHROM_W-1:0] rnd_chrom(input int tag);
      return {$urandom(), $urandom(), $urandom(), $urandom(), 22'(tag)};
   endfunction

   initial begin
      int perm [15];
      perm = '{15, 3, 7, 11, 1, 14, 5, 9, 2, 13, 6, 10, 4, 12, 8};
      rst               = 1'b1;
      bus_if.start      = 1'b0;
      bus_if.in_valid   = 1'b0;
      bus_if.in_chrom   = '0;
      bus_if.in_fitness = '0;
      bus_if.in_last    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_zero("reset");

      // Ignored inputs in IDLE: no start, valid/last pulses must do nothing.
      bus_if.in_valid   = 1'b1;
      bus_if.in_last    = 1'b1;
      bus_if.in_fitness = 16'hFFFF;
      bus_if.in_chrom   = rnd_chrom(99);
      repeat (3) begin
         @(posedge clk); #1;
         check_val("idle_ready", val_t'(bus_if.in_ready), val_t'(0));
      end
      bus_if.in_valid = 1'b0;
      bus_if.in_last  = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         check_val("idle_no_done", val_t'(bus_if.done), val_t'(0));
      end

      // Ascending 1..10, chrom equals fitness.
      for (int i = 0; i < 10; i++) begin
         cand_fit[i]   = 16'(i + 1);
         cand_chrom[i] = CHROM_W'(i + 1);
      end
      run_gen(10, -1, 1'b0);

      // Overflow: permutation of 1..15, started in the done cycle.
      for (int i = 0; i < 15; i++) begin
         cand_fit[i]   = 16'(perm[i]);
         cand_chrom[i] = rnd_chrom(perm[i]);
      end
      run_gen(15, -1, 1'b0);

      // Ties: A(5), B(9), C(5) -> B, A, C.
      cand_fit[0] = 16'd5; cand_chrom[0] = CHROM_W'(32'hA);
      cand_fit[1] = 16'd9; cand_chrom[1] = CHROM_W'(32'hB);
      cand_fit[2] = 16'd5; cand_chrom[2] = CHROM_W'(32'hC);
      run_gen(3, -1, 1'b0);

      // Partial fill with a stray start during COLLECT.
      for (int i = 0; i < 3; i++) begin
         cand_fit[i]   = 16'($urandom_range(1, 500));
         cand_chrom[i] = rnd_chrom(i);
      end
      run_gen(3, 1, 1'b0);

      // Extremes: a single zero-fitness candidate, then max fitness mixed in.
      cand_fit[0] = 16'd0; cand_chrom[0] = rnd_chrom(7);
      run_gen(1, -1, 1'b0);
      for (int i = 0; i < 12; i++) begin
         cand_fit[i]   = (i % 4 == 3) ? 16'hFFFF : 16'($urandom_range(0, 6));
         cand_chrom[i] = rnd_chrom(i);
      end
      run_gen(12, -1, 1'b0);

      // Reset mid-COLLECT after a prior publish.
      @(posedge clk); #1;
      bus_if.start = 1'b1;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus_if.in_valid   = 1'b1;
         bus_if.in_fitness = 16'(100 + i);
         bus_if.in_chrom   = rnd_chrom(i);
         @(posedge clk); #1;
      end
      bus_if.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_zero("collect_rst");
      repeat (3) begin
         @(posedge clk); #1;
         check_val("collect_rst_no_done", val_t'(bus_if.done), val_t'(0));
      end

      // Fresh generation after reset, with random fitness and ties.
      for (int i = 0; i < 14; i++) begin
         cand_fit[i]   = 16'($urandom_range(0, 20));
         cand_chrom[i] = rnd_chrom(i);
      end
      run_gen(14, -1, 1'b0);

      // Reset during PUBLISH must suppress done and clear outputs.
      for (int i = 0; i < 5; i++) begin
         cand_fit[i]   = 16'(i * 3 + 1);
         cand_chrom[i] = rnd_chrom(i);
      end
      run_gen(5, -1, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      check_val("done_count", val_t'(n_done), val_t'(n_pushed));
      check_val("queue_empty", val_t'(exp_q.size()), val_t'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
